// File: rtl/hdmi_tx_pkg.sv
// hdmi_tx_pkg: shared constants for the HDMI transmitter configuration path
package hdmi_tx_pkg;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;
  localparam logic [2:0] ST_CHECK = 3'd5;
  localparam logic [7:0] ADV_SLAVE_ADDR = 8'h72;
  localparam int REG_WORD_W = 16;
endpackage

// File: rtl/hdmi_config_rom.sv
// hdmi_config_rom: fixed {register, value} write table, zero past NUM_REGS
module hdmi_config_rom
  import hdmi_tx_pkg::*;
#(
  parameter int NUM_REGS = 8
) (
  input  logic [7:0]            index,
  output logic [REG_WORD_W-1:0] word
);
  logic [REG_WORD_W-1:0] tbl;
  always_comb begin
    case (index)
      8'd0:    tbl = 16'h4110;
      8'd1:    tbl = 16'h9803;
      8'd2:    tbl = 16'h9AE0;
      8'd3:    tbl = 16'h9C30;
      8'd4:    tbl = 16'h9D61;
      8'd5:    tbl = 16'hA2A4;
      8'd6:    tbl = 16'hA3A4;
      8'd7:    tbl = 16'hD6C0;
      default: tbl = 16'h0000;
    endcase
    word = (32'(index) < NUM_REGS) ? tbl : 16'h0000;
  end
endmodule

// File: rtl/hdmi_config_sequencer.sv
// hdmi_config_sequencer: walks the register table through the I2C master,
// retrying NACKed or timed-out writes, on go or hot-plug.
module hdmi_config_sequencer
  import hdmi_tx_pkg::*;
#(
  parameter int         NUM_REGS       = 8,
  parameter int         MAX_RETRY      = 3,
  parameter int         GAP_CYCLES     = 4,
  parameter int         TIMEOUT_CYCLES = 255,
  parameter logic [7:0] SLAVE_ADDR     = ADV_SLAVE_ADDR
) (
  input  logic                  clock_100khz,
  input  logic                  reset,
  input  logic                  hpd,
  input  logic                  go,
  input  logic                  i2c_stop,
  input  logic                  i2c_ack,
  output logic                  i2c_start,
  output logic [REG_WORD_W-1:0] i2c_register_data,
  output logic [7:0]            i2c_slave_address,
  output logic                  config_busy,
  output logic                  config_done,
  output logic                  config_error,
  output logic [7:0]            entry_index
);
  logic [2:0] state;
  logic [2:0] hpd_sync;
  logic stop_prev, nack, timed_out, hpd_drop;
  logic [3:0] retry;
  logic [7:0] gcnt, tcnt;
  logic [REG_WORD_W-1:0] rom_word;
  logic hpd_rise, hpd_fall, trigger, stop_fall, fail, last;
  hdmi_config_rom #(.NUM_REGS(NUM_REGS)) u_rom (.index(entry_index), .word(rom_word));
  assign hpd_rise  = hpd_sync[1] & ~hpd_sync[2];
  assign hpd_fall  = ~hpd_sync[1] & hpd_sync[2];
  assign trigger   = go | hpd_rise;
  assign stop_fall = stop_prev & ~i2c_stop;
  assign fail      = nack | timed_out;
  assign last      = entry_index == 8'(NUM_REGS - 1);
  assign i2c_start = state == ST_START;
  always_ff @(posedge clock_100khz or negedge reset) begin
    if (!reset) begin
      state             <= ST_IDLE;
      hpd_sync          <= '0;
      stop_prev         <= 1'b1;
      nack              <= 1'b0;
      timed_out         <= 1'b0;
      hpd_drop          <= 1'b0;
      retry             <= '0;
      gcnt              <= '0;
      tcnt              <= '0;
      i2c_register_data <= '0;
      i2c_slave_address <= '0;
      config_busy       <= 1'b0;
      config_done       <= 1'b0;
      config_error      <= 1'b0;
      entry_index       <= '0;
    end else begin
      hpd_sync          <= {hpd_sync[1:0], hpd};
      stop_prev         <= i2c_stop;
      i2c_slave_address <= SLAVE_ADDR;
      if (hpd_fall && config_busy) hpd_drop <= 1'b1;
      case (state)
        ST_IDLE: if (trigger) begin
          state        <= ST_LOAD;
          entry_index  <= '0;
          config_done  <= 1'b0;
          config_error <= 1'b0;
          config_busy  <= 1'b1;
          hpd_drop     <= 1'b0;
        end
        ST_LOAD: begin
          i2c_register_data <= rom_word;
          retry             <= '0;
          state             <= ST_START;
        end
        ST_START: begin
          nack      <= 1'b0;
          timed_out <= 1'b0;
          tcnt      <= '0;
          state     <= ST_WAIT;
        end
        ST_WAIT: begin
          nack <= nack | i2c_ack;
          gcnt <= '0;
          if (tcnt != 8'hFF) tcnt <= tcnt + 8'd1;
          if (stop_fall) state <= ST_GAP;
          else if (tcnt == 8'(TIMEOUT_CYCLES)) begin
            timed_out <= 1'b1;
            state     <= ST_GAP;
          end
        end
        ST_GAP: begin
          gcnt <= gcnt + 8'd1;
          if (gcnt == 8'(GAP_CYCLES - 1)) state <= ST_CHECK;
        end
        ST_CHECK: begin
          // an unplug lets the in-flight write finish, then abandons the table
          if (hpd_drop) begin
            hpd_drop    <= 1'b0;
            config_busy <= 1'b0;
            state       <= ST_IDLE;
          end else if (!fail) begin
            if (last) begin
              config_done <= 1'b1;
              config_busy <= 1'b0;
              state       <= ST_IDLE;
            end else begin
              entry_index <= entry_index + 8'd1;
              state       <= ST_LOAD;
            end
          end else if (retry < 4'(MAX_RETRY)) begin
            retry <= retry + 4'd1;
            state <= ST_START;
          end else begin
            config_error <= 1'b1;
            config_busy  <= 1'b0;
            state        <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hdmi_config_sequencer.sv
// tb_hdmi_config_sequencer: directed checks with a simple I2C controller responder
module tb_hdmi_config_sequencer;
  logic clk = 0, reset = 0, hpd = 0, go = 0, i2c_stop = 0, i2c_ack = 0;
  logic i2c_start, config_busy, config_done, config_error;
  logic [15:0] i2c_register_data;
  logic [7:0] i2c_slave_address, entry_index;
  int total = 0, bad = 0;
  int mode = 0, nack_at = 0, starts = 0, base = 0, dbl = 0;
  logic prev_start = 0;
  logic [15:0] log_q[$];

  hdmi_config_sequencer #(.NUM_REGS(3), .MAX_RETRY(2), .GAP_CYCLES(4), .TIMEOUT_CYCLES(255)) dut (
    .clock_100khz(clk), .reset(reset), .hpd(hpd), .go(go), .i2c_stop(i2c_stop), .i2c_ack(i2c_ack),
    .i2c_start(i2c_start), .i2c_register_data(i2c_register_data), .i2c_slave_address(i2c_slave_address),
    .config_busy(config_busy), .config_done(config_done), .config_error(config_error),
    .entry_index(entry_index));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (prev_start && i2c_start) dbl = dbl + 1;
    prev_start = i2c_start;
  end

  // mode 0/1/2 answer every start (1 NACKs start number nack_at, 2 NACKs all); mode 3 holds stop high
  initial forever begin
    @(posedge clk); #1;
    i2c_stop = (mode == 3);
    if (i2c_start) begin
      starts = starts + 1;
      log_q.push_back(i2c_register_data);
      if (mode != 3) begin
        repeat (3) @(posedge clk);
        #1 i2c_ack = (mode == 2) || (mode == 1 && starts == nack_at);
        i2c_stop = 1;
        @(posedge clk); #1 i2c_ack = 0;
        @(posedge clk); #1 i2c_stop = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic pulse_go();
    @(posedge clk); #1 go = 1;
    @(posedge clk); #1 go = 0;
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while (config_busy && n < lim) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle", config_busy, 0);
  endtask

  task automatic seq_start();
    base = starts;
    log_q.delete();
  endtask

  initial begin
    #12;
    chk("rst_start", i2c_start, 0);
    chk("rst_data", i2c_register_data, 0);
    chk("rst_addr", i2c_slave_address, 0);
    chk("rst_flags", {config_busy, config_done, config_error}, 0);
    chk("rst_index", entry_index, 0);
    #5 reset = 1;
    repeat (3) @(posedge clk); #1;
    chk("addr", i2c_slave_address, 8'h72);

    // normal run with trigger latency
    mode = 0; seq_start();
    @(posedge clk); #1 go = 1;
    @(posedge clk); #1 go = 0;
    chk("go_lat0", i2c_start, 0);
    @(posedge clk); #1;
    chk("go_lat1", i2c_start, 1);
    wait_idle(2000);
    chk("n_starts", starts - base, 3);
    chk("n_d0", log_q[0], 16'h4110);
    chk("n_d1", log_q[1], 16'h9803);
    chk("n_d2", log_q[2], 16'h9AE0);
    chk("n_flags", {config_done, config_error}, 2'b10);
    chk("n_index", entry_index, 2);

    // single NACK on entry 1
    mode = 1; seq_start(); nack_at = base + 2;
    pulse_go();
    wait_idle(2000);
    chk("k_starts", starts - base, 4);
    chk("k_d1", log_q[1], 16'h9803);
    chk("k_d2", log_q[2], 16'h9803);
    chk("k_d3", log_q[3], 16'h9AE0);
    chk("k_flags", {config_done, config_error}, 2'b10);

    // retry exhaustion on entry 0
    mode = 2; seq_start();
    pulse_go();
    wait_idle(2000);
    chk("r_starts", starts - base, 3);
    chk("r_d0", log_q[0], 16'h4110);
    chk("r_d2", log_q[2], 16'h4110);
    chk("r_flags", {config_done, config_error}, 2'b01);
    chk("r_index", entry_index, 0);

    // timeout with stop held high
    mode = 3; seq_start();
    pulse_go();
    repeat (100) @(posedge clk); #1;
    chk("t_one", starts - base, 1);
    wait_idle(3000);
    chk("t_starts", starts - base, 3);
    chk("t_flags", {config_done, config_error}, 2'b01);

    // hot plug latency and unplug during entry 1
    mode = 0; seq_start();
    @(posedge clk); #1 hpd = 1;
    repeat (3) @(posedge clk); #1;
    chk("h_lat0", i2c_start, 0);
    @(posedge clk); #1;
    chk("h_lat1", i2c_start, 1);
    for (int n = 0; n < 200 && starts - base < 2; n++) begin
      @(posedge clk); #1;
    end
    hpd = 0;
    wait_idle(2000);
    chk("h_starts", starts - base, 2);
    chk("h_flags", {config_done, config_error}, 2'b00);
    chk("h_index", entry_index, 1);

    // go and hpd rise together give one sequence
    seq_start();
    @(posedge clk); #1 go = 1; hpd = 1;
    @(posedge clk); #1 go = 0;
    wait_idle(2000);
    repeat (20) @(posedge clk); #1;
    chk("gh_starts", starts - base, 3);
    chk("gh_busy", config_busy, 0);
    hpd = 0;
    repeat (5) @(posedge clk);

    // async reset mid-WAIT, then restart
    mode = 3; seq_start();
    pulse_go();
    repeat (4) @(posedge clk); #1;
    chk("m_busy", config_busy, 1);
    reset = 0; #1;
    chk("m_out", {i2c_start, config_busy, config_done, config_error}, 0);
    chk("m_data", i2c_register_data, 0);
    chk("m_addr", i2c_slave_address, 0);
    #2 reset = 1;
    mode = 0; seq_start();
    pulse_go();
    wait_idle(2000);
    chk("m_starts", starts - base, 3);
    chk("m_d0", log_q[0], 16'h4110);
    chk("m_done", config_done, 1);

    chk("start_2x", dbl, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
